// File: rtl/apb_bar_pkg.sv
// Shared types and default address-map generator for the APB base/mask interconnect.
package apb_bar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DECERR
    } state_e;

    localparam int MAX_SLV = 32;
    localparam int MAX_AW  = 64;

    localparam logic [MAX_AW-1:0] BASE_STEP = 64'h1000;
    localparam logic [MAX_AW-1:0] DEF_MASK  = 64'h0FFF;

    // Flattened map: entry i occupies bits [i*aw +: aw]; callers cast to their width.
    function automatic logic [MAX_SLV*MAX_AW-1:0] def_map(
        input int n,
        input int aw,
        input bit is_mask
    );
        logic [MAX_SLV*MAX_AW-1:0] r;
        logic [MAX_AW-1:0]         v;
        r = '0;
        for (int i = 0; i < MAX_SLV; i++) begin
            v = is_mask ? DEF_MASK : BASE_STEP * MAX_AW'(i);
            for (int b = 0; b < MAX_AW; b++) begin
                if (i < n && b < aw) r[i*aw + b] = v[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_bus_t.sv
// APB bus bundle; master modport also carries clock and reset to the slave.
interface apb_bus_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          PCLK;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_addr_dec.sv
// Parallel base/mask window compare with lowest-index priority.
module apb_addr_dec import apb_bar_pkg::*; #(
    parameter int N_SLAVES = 4,
    parameter int AW       = 32,
    parameter logic [N_SLAVES-1:0][AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES-1:0][AW-1:0] SLV_MASK = '0,
    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] idx,
    output logic          hit
);

    // Scan high to low so the lowest matching index is the last write.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ~SLV_MASK[i]) == SLV_BASE[i]) begin
                idx = IW'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_bar_dec.sv
// APB 1:N interconnect with base/mask decode, decode-error responder
// and per-transfer timeout watchdog.
module apb_bar_dec import apb_bar_pkg::*; #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int N_SLAVES       = 4,
    parameter logic [N_SLAVES-1:0][APB_ADDR_WIDTH-1:0] SLV_BASE =
        (N_SLAVES*APB_ADDR_WIDTH)'(def_map(N_SLAVES, APB_ADDR_WIDTH, 1'b0)),
    parameter logic [N_SLAVES-1:0][APB_ADDR_WIDTH-1:0] SLV_MASK =
        (N_SLAVES*APB_ADDR_WIDTH)'(def_map(N_SLAVES, APB_ADDR_WIDTH, 1'b1)),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic     PCLK,
    input  logic     PRESET,
    apb_bus_t.slave  slave_port,
    apb_bus_t.master master_port [N_SLAVES],
    output logic     decerr_o,
    output logic     timeout_o
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    state_e        state;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] dec_idx;
    logic          hit_q;
    logic          dec_hit;
    logic [CW-1:0] cnt;
    logic          setup;
    logic          rdy;
    logic          tmo;

    logic [N_SLAVES-1:0] psel;
    logic [N_SLAVES-1:0] s_rdy;
    logic [N_SLAVES-1:0] s_err;
    logic [N_SLAVES-1:0][APB_DATA_WIDTH-1:0] s_rdata;

    apb_addr_dec #(
        .N_SLAVES (N_SLAVES),
        .AW       (APB_ADDR_WIDTH),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (slave_port.PADDR),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_port
        assign master_port[i].PCLK    = PCLK;
        assign master_port[i].PRESETn = ~PRESET;
        assign master_port[i].PSEL    = psel[i];
        assign master_port[i].PENABLE = slave_port.PENABLE;
        assign master_port[i].PWRITE  = slave_port.PWRITE;
        assign master_port[i].PWDATA  = slave_port.PWDATA;
        assign master_port[i].PADDR   = slave_port.PADDR & SLV_MASK[i];
        assign s_rdy[i]   = master_port[i].PREADY;
        assign s_err[i]   = master_port[i].PSLVERR;
        assign s_rdata[i] = master_port[i].PRDATA;
    end

    assign setup = !PRESET && slave_port.PSEL && !slave_port.PENABLE;
    assign rdy   = s_rdy[idx_q];
    // A slave answer in the deadline cycle beats the watchdog.
    assign tmo   = WDOG_EN && (cnt == CNT_MAX) && !rdy;

    always_comb begin
        psel               = '0;
        slave_port.PREADY  = 1'b0;
        slave_port.PSLVERR = 1'b0;
        slave_port.PRDATA  = '0;
        if (!PRESET) begin
            unique case (state)
                IDLE: begin
                    if (setup && dec_hit) psel[dec_idx] = 1'b1;
                end
                ACCESS: begin
                    if (slave_port.PSEL && hit_q) begin
                        if (rdy) begin
                            psel[idx_q]        = 1'b1;
                            slave_port.PREADY  = 1'b1;
                            slave_port.PRDATA  = s_rdata[idx_q];
                            slave_port.PSLVERR = s_err[idx_q];
                        end else if (tmo) begin
                            slave_port.PREADY  = 1'b1;
                            slave_port.PSLVERR = 1'b1;
                        end else begin
                            psel[idx_q] = 1'b1;
                        end
                    end
                end
                DECERR: begin
                    if (slave_port.PSEL) begin
                        slave_port.PREADY  = 1'b1;
                        slave_port.PSLVERR = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            cnt       <= '0;
            decerr_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            decerr_o  <= 1'b0;
            timeout_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        idx_q <= dec_idx;
                        hit_q <= dec_hit;
                        cnt   <= '0;
                        state <= dec_hit ? ACCESS : DECERR;
                    end
                end
                ACCESS: begin
                    if (!slave_port.PSEL || rdy) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tmo) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        timeout_o <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECERR: begin
                    state    <= IDLE;
                    decerr_o <= slave_port.PSEL;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
